// File: rtl/axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_sram_slave
// Brief    : AXI4 subordinate backed by a 32-bit word SRAM, one burst in flight
// Revision : 1.0  initial release
// ============================================================================
module axi4_sram_slave #(
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h0F00_0000,
    parameter int              MEM_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          awvalid,
    output logic          awready,
    input  logic [AW-1:0] awaddr,
    input  logic [3:0]    awid,
    input  logic [7:0]    awlen,
    input  logic [2:0]    awsize,
    input  logic [1:0]    awburst,
    input  logic          awlock,
    input  logic [3:0]    awcache,
    input  logic [2:0]    awprot,
    input  logic          wvalid,
    output logic          wready,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          wlast,
    output logic          bvalid,
    input  logic          bready,
    output logic [1:0]    bresp,
    output logic [3:0]    bid,
    input  logic          arvalid,
    output logic          arready,
    input  logic [AW-1:0] araddr,
    input  logic [3:0]    arid,
    input  logic [7:0]    arlen,
    input  logic [2:0]    arsize,
    input  logic [1:0]    arburst,
    input  logic          arlock,
    input  logic [3:0]    arcache,
    input  logic [2:0]    arprot,
    output logic          rvalid,
    input  logic          rready,
    output logic [31:0]   rdata,
    output logic [1:0]    rresp,
    output logic          rlast,
    output logic [3:0]    rid
);

    localparam int                 c_IDX_W       = $clog2(MEM_WORDS);
    localparam int                 c_EXT_W       = AW + 16;
    localparam logic [c_EXT_W-1:0] c_BASE_X      = c_EXT_W'(BASE_ADDR);
    localparam logic [c_EXT_W-1:0] c_LIMIT_X     = c_BASE_X + (c_EXT_W'(MEM_WORDS) << 2);
    localparam logic [1:0]         c_BURST_FIXED = 2'b00;
    localparam logic [1:0]         c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]         c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]         c_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_addr;
    logic [3:0]          r_id;
    logic [7:0]          r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic [7:0]          r_beat_cnt;
    logic                r_err;
    logic                r_wlast_err;
    logic                r_prefer_wr;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rlast;
    logic [31:0]         r_mem [MEM_WORDS];

    logic                w_grant_rd;
    logic                w_grant_wr;
    logic                w_conflict;
    logic                w_last_beat;
    logic [AW-1:0]       w_req_addr;
    logic [3:0]          w_req_id;
    logic [7:0]          w_req_len;
    logic [2:0]          w_req_size;
    logic [1:0]          w_req_burst;
    logic [c_EXT_W-1:0]  w_req_end;
    logic                w_req_err;
    logic [AW-1:0]       w_next_addr;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [c_IDX_W-1:0]  w_wr_idx;
    logic [31:0]         w_rd_word;
    logic                w_mem_we;
    logic                w_unused;

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        return c_IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // Round-robin only matters when both requests arrive together.
    assign w_conflict = awvalid && arvalid;
    assign w_grant_rd = arvalid && !(awvalid && r_prefer_wr);
    assign w_grant_wr = awvalid && !w_grant_rd;

    assign w_req_addr  = w_grant_rd ? araddr  : awaddr;
    assign w_req_id    = w_grant_rd ? arid    : awid;
    assign w_req_len   = w_grant_rd ? arlen   : awlen;
    assign w_req_size  = w_grant_rd ? arsize  : awsize;
    assign w_req_burst = w_grant_rd ? arburst : awburst;

    // Beat addresses are monotonic, so checking first and last covers the burst.
    assign w_req_end = c_EXT_W'(w_req_addr) +
                       ((w_req_burst == c_BURST_FIXED) ? '0 : (c_EXT_W'(w_req_len) << w_req_size));
    assign w_req_err = (w_req_size > 3'd2) ||
                       (c_EXT_W'(w_req_addr) < c_BASE_X) ||
                       (w_req_end >= c_LIMIT_X);

    assign w_last_beat = (r_beat_cnt == r_len);
    assign w_next_addr = (r_burst == c_BURST_FIXED) ? r_addr : r_addr + (AW'(1) << r_size);
    assign w_rd_idx    = (r_state == ST_IDLE) ? word_idx(w_req_addr) : word_idx(w_next_addr);
    assign w_rd_word   = r_mem[w_rd_idx];
    assign w_wr_idx    = word_idx(r_addr);
    assign w_mem_we    = (r_state == ST_WDATA) && wvalid && !r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        awready     = 1'b0;
        arready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                arready = w_grant_rd && !rst;
                awready = w_grant_wr && !rst;
                if (arready) begin
                    w_state_nxt = ST_RDATA;
                end else if (awready) begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: begin
                wready = 1'b1;
                if (wvalid && w_last_beat) begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RDATA: begin
                rvalid = 1'b1;
                if (rready && r_rlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_id        <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
            r_wlast_err <= 1'b0;
            r_prefer_wr <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= '0;
            r_rlast     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arready || awready) begin
                        r_addr      <= w_req_addr;
                        r_id        <= w_req_id;
                        r_len       <= w_req_len;
                        r_size      <= w_req_size;
                        r_burst     <= w_req_burst;
                        r_beat_cnt  <= '0;
                        r_err       <= w_req_err;
                        r_wlast_err <= 1'b0;
                        if (w_conflict) begin
                            r_prefer_wr <= !r_prefer_wr;
                        end
                    end
                    // First read beat is fetched during the address handshake.
                    if (arready) begin
                        r_rdata <= w_req_err ? '0 : w_rd_word;
                        r_rresp <= w_req_err ? c_RESP_DECERR : c_RESP_OKAY;
                        r_rlast <= (arlen == 8'd0);
                    end
                end
                ST_WDATA: begin
                    if (wvalid) begin
                        if (wlast != w_last_beat) begin
                            r_wlast_err <= 1'b1;
                        end
                        if (!w_last_beat) begin
                            r_addr     <= w_next_addr;
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (rready && !r_rlast) begin
                        r_addr     <= w_next_addr;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        r_rdata    <= r_err ? '0 : w_rd_word;
                        r_rlast    <= (r_beat_cnt + 8'd1 == r_len);
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign bresp = !bvalid ? c_RESP_OKAY :
                   r_err ? c_RESP_DECERR :
                   r_wlast_err ? c_RESP_SLVERR : c_RESP_OKAY;
    assign bid   = bvalid ? r_id : '0;
    assign rid   = rvalid ? r_id : '0;
    assign rdata = r_rdata;
    assign rresp = r_rresp;
    assign rlast = r_rlast;

    assign w_unused = &{1'b0, awlock, awcache, awprot, arlock, arcache, arprot};

endmodule
`default_nettype wire

// File: tb/tb_axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_sram_slave
// Brief    : scoreboard bench for axi4_sram_slave against a word-array model
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_sram_slave;

    localparam logic [31:0] c_BASE  = 32'h0F00_0000;
    localparam int          c_WORDS = 1024;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic awvalid = 0, awready, awlock = 0;
    logic [31:0] awaddr = '0;
    logic [3:0] awid = '0, awcache = '0;
    logic [7:0] awlen = '0;
    logic [2:0] awsize = '0, awprot = '0;
    logic [1:0] awburst = '0;
    logic wvalid = 0, wready, wlast = 0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic bvalid, bready = 0;
    logic [1:0] bresp;
    logic [3:0] bid;
    logic arvalid = 0, arready, arlock = 0;
    logic [31:0] araddr = '0;
    logic [3:0] arid = '0, arcache = '0;
    logic [7:0] arlen = '0;
    logic [2:0] arsize = '0, arprot = '0;
    logic [1:0] arburst = '0;
    logic rvalid, rready = 0, rlast;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic [3:0] rid;

    int tests = 0;
    int fails = 0;
    int hs_seq = 0;
    int rd_hs = 0;
    int wr_hs = 0;
    int rr_mode = 2;
    bit in_reset = 1'b1;
    exp_t rq[$];
    exp_t bq[$];
    logic [31:0] mdl [c_WORDS];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    bit          wl [256];

    axi4_sram_slave dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    // Reference: beat i of a burst sits at start + i*2^size unless FIXED.
    function automatic longint beat_addr(input logic [31:0] a, input int i,
                                         input logic [2:0] sz, input logic [1:0] bt);
        if (bt == 2'b00) return longint'(a);
        return longint'(a) + longint'(i) * (longint'(1) << sz);
    endfunction

    function automatic bit burst_err(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] sz, input logic [1:0] bt);
        longint x;
        if (sz > 3'd2) return 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            x = beat_addr(a, i, sz, bt);
            if (x < longint'(c_BASE) || x >= longint'(c_BASE) + 4 * c_WORDS) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int word_of(input longint a);
        return int'(((a - longint'(c_BASE)) >> 2) % c_WORDS);
    endfunction

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        bit   err;
        bit   done;
        exp_t e;
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (arready) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL ar_timeout: arready=0, need 1");
            arvalid = 1'b0;
            return;
        end
        rd_hs = hs_seq; hs_seq++;
        err = burst_err(a, len, sz, bt);
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.resp = err ? 2'b11 : 2'b00;
            e.data = err ? 32'h0 : mdl[word_of(beat_addr(a, i, sz, bt))];
            e.last = (i == int'(len));
            rq.push_back(e);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt);
        bit   err;
        bit   mis;
        bit   done;
        int   w;
        exp_t e;
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bt;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (awready) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL aw_timeout: awready=0, need 1");
            awvalid = 1'b0;
            return;
        end
        wr_hs = hs_seq; hs_seq++;
        err = burst_err(a, len, sz, bt);
        mis = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (wl[i] != (i == int'(len))) mis = 1'b1;
            if (!err) begin
                w = word_of(beat_addr(a, i, sz, bt));
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mdl[w][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        e.id = id; e.resp = err ? 2'b11 : (mis ? 2'b10 : 2'b00); e.data = '0; e.last = 1'b0;
        bq.push_back(e);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            done = 1'b0;
            for (int k = 0; k < 3000 && !done; k++) begin
                @(negedge clk);
                if (wready) done = 1'b1;
            end
            if (!done) begin
                tests++; fails++;
                $display("FAIL w_timeout: wready=0, need 1");
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic fill_w(input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == int'(len));
        end
    endtask

    task automatic drain(input string what);
        for (int k = 0; k < 6000 && (rq.size() != 0 || bq.size() != 0); k++) @(negedge clk);
        if (rq.size() != 0 || bq.size() != 0) begin
            tests++; fails++;
            $display("FAIL %s_drain: %0d r and %0d b responses outstanding, need 0", what, rq.size(), bq.size());
            rq.delete(); bq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin : ready_drivers
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       rready = 1'b1;
                1:       rready = ~rready;
                default: rready = ($urandom_range(0, 3) != 0);
            endcase
            bready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : monitor
        exp_t        e;
        bit          armed;
        logic [31:0] held;
        armed = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                armed = 1'b0;
            end else begin
                if (armed) begin
                    tests++;
                    if (rvalid !== 1'b1 || rdata !== held) begin
                        fails++;
                        $display("FAIL r_stall_stable: rvalid=%0b rdata=%h, need rvalid=1 rdata=%h", rvalid, rdata, held);
                    end
                end
                armed = rvalid && !rready;
                held  = rdata;
                if (rvalid && rready) begin
                    tests++;
                    if (rq.size() == 0) begin
                        fails++;
                        $display("FAIL r_unexpected: beat rdata=%h with no read pending", rdata);
                    end else begin
                        e = rq.pop_front();
                        if (rid !== e.id || rresp !== e.resp || rdata !== e.data || rlast !== e.last) begin
                            fails++;
                            $display("FAIL r_beat: got id=%h resp=%b data=%h last=%b, need id=%h resp=%b data=%h last=%b",
                                     rid, rresp, rdata, rlast, e.id, e.resp, e.data, e.last);
                        end
                    end
                end
                if (bvalid && bready) begin
                    tests++;
                    if (bq.size() == 0) begin
                        fails++;
                        $display("FAIL b_unexpected: bresp=%b with no write pending", bresp);
                    end else begin
                        e = bq.pop_front();
                        if (bid !== e.id || bresp !== e.resp) begin
                            fails++;
                            $display("FAIL b_resp: got id=%h resp=%b, need id=%h resp=%b", bid, bresp, e.id, e.resp);
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        int          sel;

        repeat (2) @(negedge clk);
        tests++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || {bresp, rresp, bid, rid} !== 12'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: rdy/vld=%b resp/id=%b rdata=%h, need all 0",
                     {awready, arready, wready, bvalid, rvalid, rlast}, {bresp, rresp, bid, rid}, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_reset = 1'b0;

        // Preload every word so the model never has to guess SRAM contents.
        for (int k = 0; k < 4; k++) begin
            fill_w(8'd255);
            do_write(c_BASE + 32'(k * 1024), 4'h1, 8'd255, 3'd2, 2'b01);
        end
        drain("init");

        fork
            do_read(c_BASE + 32'h40, 4'h3, 8'd0, 3'd2, 2'b01);
            begin fill_w(8'd0); do_write(c_BASE + 32'h80, 4'hC, 8'd0, 3'd2, 2'b01); end
        join
        drain("conflict1");
        tests++;
        if (!(rd_hs < wr_hs)) begin
            fails++;
            $display("FAIL rr_first: read order %0d write order %0d, need read first", rd_hs, wr_hs);
        end
        fork
            do_read(c_BASE + 32'h80, 4'h6, 8'd0, 3'd2, 2'b01);
            begin fill_w(8'd0); do_write(c_BASE + 32'h44, 4'hA, 8'd0, 3'd2, 2'b01); end
        join
        drain("conflict2");
        tests++;
        if (!(wr_hs < rd_hs)) begin
            fails++;
            $display("FAIL rr_second: read order %0d write order %0d, need write first", rd_hs, wr_hs);
        end

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        do_write(c_BASE, 4'h2, 8'd0, 3'd2, 2'b01);
        do_read(c_BASE, 4'h2, 8'd0, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3);
        end
        do_write(c_BASE + 32'h10, 4'h4, 8'd3, 3'd2, 2'b01);
        do_read(c_BASE + 32'h10, 4'h5, 8'd3, 3'd2, 2'b01);
        wd[0] = 32'h11223344; ws[0] = 4'hF; wl[0] = 1'b1;
        do_write(c_BASE + 32'h100, 4'h7, 8'd0, 3'd2, 2'b01);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0010; wl[0] = 1'b1;
        do_write(c_BASE + 32'h100, 4'h7, 8'd0, 3'd2, 2'b01);
        do_read(c_BASE + 32'h100, 4'h8, 8'd0, 3'd2, 2'b01);
        do_read(32'h1000_0000, 4'hE, 8'd1, 3'd2, 2'b01);
        fill_w(8'd1); wl[0] = 1'b1;
        do_write(c_BASE + 32'h200, 4'hB, 8'd1, 3'd2, 2'b01);
        drain("directed");

        rr_mode = 1;
        do_read(c_BASE + 32'h300, 4'hD, 8'd7, 3'd2, 2'b01);
        drain("stall");
        rr_mode = 2;

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = c_BASE - 32'($urandom_range(1, 16));
            else if (sel == 1) a = c_BASE + 32'h1000 - 32'($urandom_range(0, 40));
            else               a = c_BASE + 32'($urandom_range(0, 4095));
            len = 8'($urandom_range(0, 15));
            sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wd[i] = $urandom; ws[i] = 4'($urandom); wl[i] = (i == int'(len));
                end
                if ($urandom_range(0, 7) == 0) wl[$urandom_range(0, int'(len))] ^= 1'b1;
                do_write(a, 4'($urandom), len, sz, 2'($urandom_range(0, 2)));
            end else begin
                do_read(a, 4'($urandom), len, sz, 2'($urandom_range(0, 2)));
            end
        end
        drain("random");

        rr_mode = 0;
        do_read(c_BASE + 32'h200, 4'h9, 8'd15, 3'd2, 2'b01);
        for (int k = 0; k < 200 && rq.size() > 12; k++) @(negedge clk);
        @(posedge clk); #1;
        in_reset = 1'b1; rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0 || rlast !== 1'b0 || rresp !== 2'b0) begin
            fails++;
            $display("FAIL reset_midburst: rdy/vld=%b rdata=%h rlast=%b rresp=%b, need all 0",
                     {awready, arready, wready, bvalid, rvalid}, rdata, rlast, rresp);
        end
        rq.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; in_reset = 1'b0;
        rr_mode = 2;
        do_read(c_BASE + 32'h10, 4'h5, 8'd3, 3'd2, 2'b01);
        drain("after_reset");

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
